// File: rtl/frog_pkg.sv
// +----------------------------------------------------------------------+
// | frog_pkg : shared types, coordinate width and span helper            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package frog_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [2:0] {
    PLAY  = 3'd0,
    DYING = 3'd1,
    GRACE = 3'd2,
    CLEAR = 3'd3,
    OVER  = 3'd4
  } hm_state_t;

  // Inclusive [lo, lo+len-1] test, one bit wider than a coordinate so spans never wrap.
  function automatic logic in_span(input logic [COORD_W:0] p,
                                   input logic [COORD_W:0] lo,
                                   input logic [COORD_W:0] len);
    logic [COORD_W:0] hi;
    hi = lo + len - {{COORD_W{1'b0}}, 1'b1};
    return (len != '0) && (p >= lo) && (p <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hit_manager_if.sv
// +----------------------------------------------------------------------+
// | hit_manager_if : position inputs and life/home status outputs        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface hit_manager_if
  import frog_pkg::*;
#(
  parameter int NUM_OBJ  = 16,
  parameter int SIZE_W   = 6,
  parameter int NUM_HOME = 5,
  parameter int LIFE_W   = 4
);

  logic [COORD_W-1:0]         frog_x;
  logic [COORD_W-1:0]         frog_y;
  logic [NUM_OBJ*COORD_W-1:0] obj_x;
  logic [NUM_OBJ*COORD_W-1:0] obj_y;
  logic [NUM_OBJ*SIZE_W-1:0]  obj_w;
  logic [NUM_OBJ*SIZE_W-1:0]  obj_h;
  logic [NUM_OBJ-1:0]         obj_en;
  logic                       water;
  logic                       restart;

  logic                       frog_reset;
  logic [LIFE_W-1:0]          lives;
  logic [NUM_HOME-1:0]        home_filled;
  logic                       level_clear;
  logic                       game_over;
  logic                       invuln;

  modport master (
    output frog_x, frog_y, obj_x, obj_y, obj_w, obj_h, obj_en, water, restart,
    input  frog_reset, lives, home_filled, level_clear, game_over, invuln
  );

  modport slave (
    input  frog_x, frog_y, obj_x, obj_y, obj_w, obj_h, obj_en, water, restart,
    output frog_reset, lives, home_filled, level_clear, game_over, invuln
  );

endinterface

`default_nettype wire

// File: rtl/hit_manager_hit_probe.sv
// +----------------------------------------------------------------------+
// | hit_probe : frog probe points against one obstacle rectangle         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module hit_probe
  import frog_pkg::*;
#(
  parameter int SIZE_W = 6
) (
  input  logic [COORD_W:0]   i_pl,
  input  logic [COORD_W:0]   i_pr,
  input  logic [COORD_W:0]   i_py,
  input  logic [COORD_W-1:0] i_ox,
  input  logic [COORD_W-1:0] i_oy,
  input  logic [SIZE_W-1:0]  i_w,
  input  logic [SIZE_W-1:0]  i_h,
  input  logic               i_en,
  output logic               o_hit
);

  logic [COORD_W:0] w_ox;
  logic [COORD_W:0] w_oy;
  logic [COORD_W:0] w_w;
  logic [COORD_W:0] w_h;

  assign w_ox = {1'b0, i_ox};
  assign w_oy = {1'b0, i_oy};
  assign w_w  = (COORD_W+1)'(i_w);
  assign w_h  = (COORD_W+1)'(i_h);

  // A zero size collapses the span to empty, disabling the channel.
  assign o_hit = i_en && in_span(i_py, w_oy, w_h) &&
                 (in_span(i_pl, w_ox, w_w) || in_span(i_pr, w_ox, w_w));

endmodule

`default_nettype wire

// File: rtl/hit_manager.sv
// +----------------------------------------------------------------------+
// | hit_manager : per-frame collision events and life/respawn/home FSM   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module hit_manager
  import frog_pkg::*;
#(
  parameter int NUM_OBJ      = 16,
  parameter int SIZE_W       = 6,
  parameter int NUM_HOME     = 5,
  parameter int LIFE_W       = 4,
  parameter int MAX_LIVES    = 3,
  parameter int WALL_L       = 207,
  parameter int WALL_R       = 431,
  parameter int FROG_L       = 2,
  parameter int FROG_R       = 13,
  parameter int FROG_MID     = 8,
  parameter int HOME_X0      = 215,
  parameter int HOME_PITCH   = 46,
  parameter int HOME_W       = 25,
  parameter int HOME_Y_MAX   = 160,
  parameter int DEATH_FRAMES = 16,
  parameter int GRACE_FRAMES = 32
) (
  input  logic         frame_clk,
  input  logic         Reset_n,
  hit_manager_if.slave bus
);

  localparam int c_idx_w   = (NUM_HOME > 1) ? $clog2(NUM_HOME) : 1;
  localparam int c_cnt_max = (GRACE_FRAMES > DEATH_FRAMES) ? GRACE_FRAMES : DEATH_FRAMES;
  localparam int c_cnt_w   = (c_cnt_max > 2) ? $clog2(c_cnt_max) : 1;

  localparam logic [COORD_W:0]  c_frog_l   = (COORD_W+1)'(FROG_L);
  localparam logic [COORD_W:0]  c_frog_r   = (COORD_W+1)'(FROG_R);
  localparam logic [COORD_W:0]  c_frog_mid = (COORD_W+1)'(FROG_MID);
  localparam logic [COORD_W:0]  c_wall_l   = (COORD_W+1)'(WALL_L);
  localparam logic [COORD_W:0]  c_wall_r   = (COORD_W+1)'(WALL_R);
  localparam logic [COORD_W:0]  c_home_y   = (COORD_W+1)'(HOME_Y_MAX);
  localparam logic [c_cnt_w-1:0] c_death_ld = c_cnt_w'(DEATH_FRAMES - 1);
  localparam logic [c_cnt_w-1:0] c_grace_ld = c_cnt_w'(GRACE_FRAMES - 1);
  localparam logic [LIFE_W-1:0]  c_lives_ld = LIFE_W'(MAX_LIVES);

  logic [COORD_W:0]     w_pl;
  logic [COORD_W:0]     w_pr;
  logic [COORD_W:0]     w_py;
  logic [NUM_OBJ-1:0]   w_obj_hit;
  logic [NUM_HOME-1:0]  w_home_hit;
  logic [c_idx_w-1:0]   w_home_idx;
  logic                 w_wall;

  logic                 r_ev_wall;
  logic                 r_ev_obj;
  logic                 r_ev_water;
  logic [c_idx_w-1:0]   r_ev_home_idx;
  logic                 r_ev_home_valid;

  hm_state_t            r_state;
  hm_state_t            w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [LIFE_W-1:0]    r_lives;
  logic [LIFE_W-1:0]    w_lives_nxt;
  logic [NUM_HOME-1:0]  r_home_filled;
  logic [NUM_HOME-1:0]  w_home_nxt;
  logic [NUM_HOME-1:0]  w_home_bit;
  logic [NUM_HOME-1:0]  w_fill_mask;
  logic                 w_death;
  logic                 w_fill;

  assign w_pl   = {1'b0, bus.frog_x} + c_frog_l;
  assign w_pr   = {1'b0, bus.frog_x} + c_frog_r;
  assign w_py   = {1'b0, bus.frog_y} + c_frog_mid;
  assign w_wall = (w_pl > c_wall_r) || (w_pr < c_wall_l);

  for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
    hit_probe #(.SIZE_W(SIZE_W)) u_probe (
      .i_pl  (w_pl),
      .i_pr  (w_pr),
      .i_py  (w_py),
      .i_ox  (bus.obj_x[gi*COORD_W +: COORD_W]),
      .i_oy  (bus.obj_y[gi*COORD_W +: COORD_W]),
      .i_w   (bus.obj_w[gi*SIZE_W +: SIZE_W]),
      .i_h   (bus.obj_h[gi*SIZE_W +: SIZE_W]),
      .i_en  (bus.obj_en[gi]),
      .o_hit (w_obj_hit[gi])
    );
  end

  for (genvar gk = 0; gk < NUM_HOME; gk++) begin : g_home
    localparam logic [COORD_W:0] c_lo = (COORD_W+1)'(HOME_X0 + gk*HOME_PITCH);
    localparam logic [COORD_W:0] c_hi = (COORD_W+1)'(HOME_X0 + gk*HOME_PITCH + HOME_W - 1);
    assign w_home_hit[gk] = (w_pl >= c_lo) && (w_pr <= c_hi) && (w_py <= c_home_y);
  end

  // Slots never overlap; the lowest index is taken if geometry is ever misconfigured.
  always_comb begin
    w_home_idx = '0;
    for (int k = NUM_HOME - 1; k >= 0; k--) begin
      if (w_home_hit[k]) w_home_idx = c_idx_w'(k);
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ev_wall       <= 1'b0;
      r_ev_obj        <= 1'b0;
      r_ev_water      <= 1'b0;
      r_ev_home_idx   <= '0;
      r_ev_home_valid <= 1'b0;
    end else if (bus.restart) begin
      r_ev_wall       <= 1'b0;
      r_ev_obj        <= 1'b0;
      r_ev_water      <= 1'b0;
      r_ev_home_idx   <= '0;
      r_ev_home_valid <= 1'b0;
    end else begin
      r_ev_wall       <= w_wall;
      r_ev_obj        <= |w_obj_hit;
      r_ev_water      <= bus.water;
      r_ev_home_idx   <= w_home_idx;
      r_ev_home_valid <= |w_home_hit;
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= PLAY;
      r_cnt         <= '0;
      r_lives       <= c_lives_ld;
      r_home_filled <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_lives       <= w_lives_nxt;
      r_home_filled <= w_home_nxt;
    end
  end

  assign w_home_bit  = NUM_HOME'(1) << r_ev_home_idx;
  assign w_fill_mask = r_home_filled | w_home_bit;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lives_nxt = r_lives;
    w_home_nxt  = r_home_filled;
    w_death     = 1'b0;
    w_fill      = 1'b0;

    case (r_state)
      PLAY, GRACE: begin
        if (r_state == GRACE) begin
          if (r_cnt == '0) w_state_nxt = PLAY;
          else             w_cnt_nxt   = r_cnt - c_cnt_w'(1);
        end
        // Priority wall > obstacle > home > water; GRACE only honours homes.
        if (r_state == PLAY && (r_ev_wall || r_ev_obj)) begin
          w_death = 1'b1;
        end else if (r_ev_home_valid) begin
          if (|(r_home_filled & w_home_bit)) w_death = 1'b1;
          else                               w_fill  = 1'b1;
        end else if (r_state == PLAY && r_ev_water) begin
          w_death = 1'b1;
        end

        if (w_death) begin
          w_lives_nxt = (r_lives != '0) ? r_lives - LIFE_W'(1) : '0;
          if (w_lives_nxt == '0) begin
            w_state_nxt = OVER;
          end else begin
            w_state_nxt = DYING;
            w_cnt_nxt   = c_death_ld;
          end
        end else if (w_fill) begin
          if (&w_fill_mask) begin
            w_state_nxt = CLEAR;
            w_home_nxt  = '0;
          end else begin
            w_state_nxt = DYING;
            w_cnt_nxt   = c_death_ld;
            w_home_nxt  = w_fill_mask;
          end
        end
      end
      DYING: begin
        if (r_cnt == '0) begin
          w_state_nxt = GRACE;
          w_cnt_nxt   = c_grace_ld;
        end else begin
          w_cnt_nxt = r_cnt - c_cnt_w'(1);
        end
      end
      CLEAR: begin
        w_state_nxt = GRACE;
        w_cnt_nxt   = c_grace_ld;
      end
      OVER: begin
        w_state_nxt = OVER;
      end
      default: begin
        w_state_nxt = PLAY;
      end
    endcase

    if (bus.restart) begin
      w_state_nxt = GRACE;
      w_cnt_nxt   = c_grace_ld;
      w_lives_nxt = c_lives_ld;
      w_home_nxt  = '0;
    end
  end

  assign bus.frog_reset  = (r_state == DYING) || (r_state == CLEAR) || (r_state == OVER);
  assign bus.lives       = r_lives;
  assign bus.home_filled = r_home_filled;
  assign bus.level_clear = (r_state == CLEAR);
  assign bus.game_over   = (r_state == OVER);
  assign bus.invuln      = (r_state == GRACE);

endmodule

`default_nettype wire

// File: tb/tb_hit_manager.sv
// +----------------------------------------------------------------------+
// | tb_hit_manager : scenario bench for hit_manager                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_hit_manager;
  import frog_pkg::*;

  typedef struct packed {
    logic [3:0] lives;
    logic [4:0] home;
    logic       fr;
    logic       inv;
    logic       go;
    logic       lc;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  hit_manager_if bus ();

  hit_manager dut (
    .frame_clk (clk),
    .Reset_n   (rst_n),
    .bus       (bus)
  );

  function automatic obs_t observe();
    obs_t r;
    r.lives = bus.lives;
    r.home  = bus.home_filled;
    r.fr    = bus.frog_reset;
    r.inv   = bus.invuln;
    r.go    = bus.game_over;
    r.lc    = bus.level_clear;
    return r;
  endfunction

  function automatic obs_t mk(input logic [3:0] l, input logic [4:0] h,
                              input logic fr, input logic inv, input logic go, input logic lc);
    obs_t r;
    r.lives = l; r.home = h; r.fr = fr; r.inv = inv; r.go = go; r.lc = lc;
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_frog(input int x, input int y);
    bus.frog_x = COORD_W'(x);
    bus.frog_y = COORD_W'(y);
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int w, input int h, input logic en);
    bus.obj_x[i*COORD_W +: COORD_W] = COORD_W'(x);
    bus.obj_y[i*COORD_W +: COORD_W] = COORD_W'(y);
    bus.obj_w[i*6 +: 6]             = 6'(w);
    bus.obj_h[i*6 +: 6]             = 6'(h);
    bus.obj_en[i]                   = en;
  endtask

  task automatic clear_objs();
    bus.obj_x = '0; bus.obj_y = '0; bus.obj_w = '0; bus.obj_h = '0; bus.obj_en = '0;
  endtask

  task automatic wait_play(input string tag);
    int n = 0;
    while ((bus.invuln || bus.frog_reset) && n < 200) begin
      step(1);
      n++;
    end
    checks++;
    if (bus.invuln || bus.frog_reset) begin
      errors++;
      $display("FAIL %s_timeout: got inv=%b fr=%b want inv=0 fr=0", tag, bus.invuln, bus.frog_reset);
    end
  endtask

  task automatic test_reset();
    obs_t a, e;
    rst_n = 1'b0;
    set_frog(300, 400);
    clear_objs();
    bus.water = 1'b0; bus.restart = 1'b0;
    step(2);
    rst_n = 1'b1;
    exp_q.push_back(mk(3, 5'b00000, 0, 0, 0, 0));
    step(3);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL reset: got %b want %b", a, e); end
  endtask

  task automatic test_obstacle();
    obs_t a, e;
    set_obj(4, 305, 405, 16, 16, 1'b1);
    exp_q.push_back(mk(3, 5'b00000, 0, 0, 0, 0));
    step(1);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL obs_latency: got %b want %b", a, e); end
    exp_q.push_back(mk(2, 5'b00000, 1, 0, 0, 0));
    step(1);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL obs_death: got %b want %b", a, e); end
    for (int i = 1; i < 16; i++) begin
      exp_q.push_back(mk(2, 5'b00000, 1, 0, 0, 0));
      step(1);
      a = observe(); e = exp_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL obs_dying[%0d]: got %b want %b", i, a, e); end
    end
    // Object 4 stays on the frog through the grace window.
    for (int i = 0; i < 31; i++) begin
      exp_q.push_back(mk(2, 5'b00000, 0, 1, 0, 0));
      step(1);
      a = observe(); e = exp_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL obs_grace[%0d]: got %b want %b", i, a, e); end
    end
    clear_objs();
    exp_q.push_back(mk(2, 5'b00000, 0, 1, 0, 0));
    step(1);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL obs_grace_last: got %b want %b", a, e); end
    exp_q.push_back(mk(2, 5'b00000, 0, 0, 0, 0));
    step(1);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL obs_grace_end: got %b want %b", a, e); end
  endtask

  task automatic test_disabled();
    obs_t a, e;
    set_obj(4, 305, 405, 16, 16, 1'b0);
    exp_q.push_back(mk(2, 5'b00000, 0, 0, 0, 0));
    step(3);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL obj_disabled: got %b want %b", a, e); end
    set_obj(4, 305, 405, 0, 16, 1'b1);
    exp_q.push_back(mk(2, 5'b00000, 0, 0, 0, 0));
    step(3);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL obj_zero_w: got %b want %b", a, e); end
    set_obj(4, 305, 405, 16, 0, 1'b1);
    exp_q.push_back(mk(2, 5'b00000, 0, 0, 0, 0));
    step(3);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL obj_zero_h: got %b want %b", a, e); end
    clear_objs();
  endtask

  task automatic test_home();
    obs_t a, e;
    set_frog(213, 100);
    step(1);
    set_frog(300, 400);
    exp_q.push_back(mk(2, 5'b00001, 1, 0, 0, 0));
    step(1);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL home0_fill: got %b want %b", a, e); end
    wait_play("home0_fill");
    set_frog(213, 100);
    step(1);
    set_frog(300, 400);
    exp_q.push_back(mk(1, 5'b00001, 1, 0, 0, 0));
    step(1);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL home0_repeat: got %b want %b", a, e); end
    wait_play("home0_repeat");
    for (int k = 1; k < 5; k++) begin
      set_frog(213 + 46*k, 100);
      step(1);
      set_frog(300, 400);
      if (k < 4) exp_q.push_back(mk(1, 5'((1 << (k+1)) - 1), 1, 0, 0, 0));
      else       exp_q.push_back(mk(1, 5'b00000, 1, 0, 0, 1));
      step(1);
      a = observe(); e = exp_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL home%0d_fill: got %b want %b", k, a, e); end
      if (k < 4) wait_play("home_fill");
    end
    exp_q.push_back(mk(1, 5'b00000, 0, 1, 0, 0));
    step(1);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL clear_pulse_end: got %b want %b", a, e); end
    wait_play("clear");
  endtask

  task automatic test_water_over();
    obs_t a, e;
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    exp_q.push_back(mk(3, 5'b00000, 0, 1, 0, 0));
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL restart_load: got %b want %b", a, e); end
    wait_play("restart_load");
    exp_q.push_back(mk(2, 5'b00000, 1, 0, 0, 0));
    exp_q.push_back(mk(1, 5'b00000, 1, 0, 0, 0));
    exp_q.push_back(mk(0, 5'b00000, 1, 0, 1, 0));
    bus.water = 1'b1;
    for (int j = 0; j < 3; j++) begin
      logic [3:0] prev;
      int n;
      prev = bus.lives;
      n = 0;
      while (bus.lives === prev && n < 120) begin
        step(1);
        n++;
      end
      a = observe(); e = exp_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL water_death%0d: got %b want %b", j, a, e); end
    end
    bus.water = 1'b0;
    // Game over still registers events; use it to probe span arithmetic.
    set_frog(3, 400);
    set_obj(0, 1020, 400, 10, 16, 1'b1);
    step(1);
    checks++;
    if (dut.r_ev_obj !== 1'b0) begin errors++; $display("FAIL no_wrap: got ev_obj=%b want 0", dut.r_ev_obj); end
    checks++;
    if (dut.r_ev_wall !== 1'b1) begin errors++; $display("FAIL wall_left: got ev_wall=%b want 1", dut.r_ev_wall); end
    set_obj(0, 0, 400, 10, 16, 1'b1);
    step(1);
    checks++;
    if (dut.r_ev_obj !== 1'b1) begin errors++; $display("FAIL span_low: got ev_obj=%b want 1", dut.r_ev_obj); end
    exp_q.push_back(mk(0, 5'b00000, 1, 0, 1, 0));
    step(2);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL over_hold: got %b want %b", a, e); end
    clear_objs();
    set_frog(300, 400);
  endtask

  task automatic test_restart();
    obs_t a, e;
    bus.water = 1'b1;
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    bus.water = 1'b0;
    exp_q.push_back(mk(3, 5'b00000, 0, 1, 0, 0));
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL restart_over: got %b want %b", a, e); end
    checks++;
    if (dut.r_ev_water !== 1'b0) begin errors++; $display("FAIL restart_discard: got ev_water=%b want 0", dut.r_ev_water); end
    exp_q.push_back(mk(3, 5'b00000, 0, 1, 0, 0));
    step(3);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL restart_grace: got %b want %b", a, e); end
    wait_play("restart");
  endtask

  task automatic test_back_to_back();
    obs_t a, e;
    set_frog(430, 400);
    set_obj(2, 430, 400, 16, 16, 1'b1);
    step(1);
    set_frog(300, 400);
    clear_objs();
    exp_q.push_back(mk(2, 5'b00000, 1, 0, 0, 0));
    step(1);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL wall_obj_single: got %b want %b", a, e); end
    exp_q.push_back(mk(2, 5'b00000, 1, 0, 0, 0));
    step(4);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL wall_obj_hold: got %b want %b", a, e); end
  endtask

  task automatic test_async_reset();
    obs_t a, e;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(3, 5'b00000, 0, 0, 0, 0));
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL async_reset: got %b want %b", a, e); end
    step(1);
    rst_n = 1'b1;
    exp_q.push_back(mk(3, 5'b00000, 0, 0, 0, 0));
    step(2);
    a = observe(); e = exp_q.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL after_reset: got %b want %b", a, e); end
  endtask

  initial begin
    test_reset();
    test_obstacle();
    test_disabled();
    test_home();
    test_water_over();
    test_restart();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
